div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter: none; all widths fixed at 32 bits.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: ex_valid  in  1  EX instruction valid; ex_div  in  1  signed DIV; ex_divu  in  1  unsigned DIVU; ex_flush  in  1  kill EX instruction.
REQ-004 SHALL have ports: rs_val  in  32  dividend; rt_val  in  32  divisor; both held stable by the pipeline while stall_req=1.
REQ-005 SHALL have ports: dv_en  out  1  divider start; dv_divident  out  32  magnitude dividend; dv_divisor  out  32  magnitude divisor.
REQ-006 SHALL have ports: dv_quotient  in  32; dv_remainder  in  32; dv_done  in  1 (divider idle, level).
REQ-007 SHALL have ports: stall_req  out  1  hold pipeline; hi_we/lo_we  out  1  HI/LO write strobes; hi_wdata/lo_wdata  out  32  remainder/quotient.

Function
REQ-008 SHALL implement states IDLE, LAUNCH, WAIT, DONE, DRAIN.
REQ-009 Request = ex_valid & (ex_div | ex_divu) & !ex_flush in IDLE; ex_div and ex_divu never both set.
REQ-010 On request SHALL register sign flag (ex_div), dividend sign, quotient sign (rs[31]^rt[31], signed only), and magnitudes (two's-complement absolute value when signed, raw when unsigned).
REQ-011 Divisor zero: no divider launch; IDLE->DONE; hi_wdata=rs_val, lo_wdata=0xFFFFFFFF.
REQ-012 Cache hit (cache_valid & magnitudes equal cached key): no launch; IDLE->DONE using cached unsigned results with sign fixup.
REQ-013 Otherwise IDLE->LAUNCH; dv_divident/dv_divisor load magnitudes; cache key updated to magnitudes, cache_valid cleared.
REQ-014 LAUNCH: dv_en=1 for exactly one cycle; ->WAIT (->DRAIN if ex_flush).
REQ-015 WAIT: on dv_done=1 capture dv_quotient/dv_remainder into cache, set cache_valid, ->DONE; ex_flush ->DRAIN.
REQ-016 DRAIN: on dv_done=1 capture results into cache, set cache_valid, ->IDLE; no HI/LO write; requests ignored.
REQ-017 DONE: hi_we=lo_we=1 for one cycle unless ex_flush (then both 0); ->IDLE.
REQ-018 Sign fixup: lo = q_neg ? -q : q; hi = dividend_neg ? -r : r; unsigned ops no fixup; 32-bit wrap (0x80000000/-1 -> lo=0x80000000, hi=0).
REQ-019 stall_req SHALL be combinational: 1 in IDLE on request, in LAUNCH and WAIT; 0 in DONE, DRAIN (pipeline killed), IDLE otherwise.
REQ-020 dv_en SHALL be 0 outside LAUNCH; no launch while divider busy (DRAIN guarantees this).
REQ-021 Latency, request in cycle R: miss -> write strobe in R+20 (divider 16 iterations + end); zero divisor or hit -> R+1.
REQ-022 Back-to-back: new request accepted in the cycle after DONE.

Reset
REQ-023 rst=0 at a clk edge SHALL force IDLE, cache_valid=0, cache key=0, dv_en=0, dv_divident=dv_divisor=0, hi_we=lo_we=0, hi_wdata=lo_wdata=0, from any state including mid-WAIT.
REQ-024 Divider shares rst; after reset no wait for dv_done is required.

Verification
REQ-025 DIVU 100/7 at R -> dv_en at R+1, hi_we=lo_we=1 at R+20, lo=14, hi=2, stall_req low at R+20.
REQ-026 DIV 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 7/2 -> cache hit, no dv_en, write at R+1, lo=3, hi=1.
REQ-027 DIV 0x12345678/0 -> no dv_en, write at R+1, hi=0x12345678, lo=0xFFFFFFFF.
REQ-028 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-029 Flush in 5th WAIT cycle, new DIVU 9/4 next cycle -> no write for first op, second op's dv_en only after dv_done seen in DRAIN; lo=2, hi=1.
REQ-030 rst=0 mid-WAIT -> next cycle all outputs at reset values; DIVU 100/7 afterwards completes normally (no cache hit).

Source files
------------

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Pipeline-side controller for an iterative 32-bit divider.
//            Handles DIV/DIVU issue, divide-by-zero, a one-entry result
//            cache keyed on operand magnitudes, sign fixup, flush and drain.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_div,
  input  logic        ex_divu,
  input  logic        ex_flush,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        dv_en,
  output logic [31:0] dv_divident,
  output logic [31:0] dv_divisor,
  input  logic [31:0] dv_quotient,
  input  logic [31:0] dv_remainder,
  input  logic        dv_done,
  output logic        stall_req,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;          // operation is signed DIV
  logic        dvd_neg_q, dvd_neg_d;    // raw dividend sign bit
  logic        q_neg_q, q_neg_d;        // raw rs[31]^rt[31]
  logic [31:0] dvd_q, dvd_d;            // magnitude handed to divider
  logic [31:0] dvs_q, dvs_d;
  logic        cache_valid_q, cache_valid_d;
  logic [31:0] cache_dvd_q, cache_dvd_d;
  logic [31:0] cache_dvs_q, cache_dvs_d;
  logic [31:0] cache_quo_q, cache_quo_d;
  logic [31:0] cache_rem_q, cache_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Two's-complement negate when requested; 32-bit wrap is intentional.
  function automatic logic [31:0] fixup(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic        req;
  logic        rs_neg, rt_neg;
  logic [31:0] mag_rs, mag_rt;
  logic        hit;

  assign req    = ex_valid & (ex_div | ex_divu) & ~ex_flush;
  assign rs_neg = ex_div & rs_val[31];
  assign rt_neg = ex_div & rt_val[31];
  assign mag_rs = fixup(rs_neg, rs_val);
  assign mag_rt = fixup(rt_neg, rt_val);
  assign hit    = cache_valid_q & (mag_rs == cache_dvd_q) & (mag_rt == cache_dvs_q);

  assign dv_divident = dvd_q;
  assign dv_divisor  = dvs_q;
  assign hi_wdata    = hi_q;
  assign lo_wdata    = lo_q;

  // Next-state, datapath next values and combinational outputs.
  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    dvd_neg_d     = dvd_neg_q;
    q_neg_d       = q_neg_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    cache_valid_d = cache_valid_q;
    cache_dvd_d   = cache_dvd_q;
    cache_dvs_d   = cache_dvs_q;
    cache_quo_d   = cache_quo_q;
    cache_rem_d   = cache_rem_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    dv_en         = 1'b0;
    stall_req     = 1'b0;
    hi_we         = 1'b0;
    lo_we         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          stall_req = 1'b1;
          sign_d    = ex_div;
          dvd_neg_d = rs_val[31];
          q_neg_d   = rs_val[31] ^ rt_val[31];
          if (rt_val == 32'd0) begin
            // Divide by zero: no launch, fixed architectural result.
            hi_d    = rs_val;
            lo_d    = 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else if (hit) begin
            lo_d    = fixup(rs_neg ^ rt_neg, cache_quo_q);
            hi_d    = fixup(rs_neg, cache_rem_q);
            state_d = S_DONE;
          end else begin
            dvd_d         = mag_rs;
            dvs_d         = mag_rt;
            cache_dvd_d   = mag_rs;
            cache_dvs_d   = mag_rt;
            cache_valid_d = 1'b0;
            state_d       = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        dv_en     = 1'b1;
        stall_req = 1'b1;
        state_d   = ex_flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (ex_flush) begin
          state_d = S_DRAIN;
        end else if (dv_done) begin
          cache_quo_d   = dv_quotient;
          cache_rem_d   = dv_remainder;
          cache_valid_d = 1'b1;
          lo_d          = fixup(sign_q & q_neg_q, dv_quotient);
          hi_d          = fixup(sign_q & dvd_neg_q, dv_remainder);
          state_d       = S_DONE;
        end
      end
      S_DRAIN: begin
        // Divider still busy with a killed op; keep its result for the cache.
        if (dv_done) begin
          cache_quo_d   = dv_quotient;
          cache_rem_d   = dv_remainder;
          cache_valid_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_DONE: begin
        hi_we   = ~ex_flush;
        lo_we   = ~ex_flush;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      sign_q        <= 1'b0;
      dvd_neg_q     <= 1'b0;
      q_neg_q       <= 1'b0;
      dvd_q         <= 32'd0;
      dvs_q         <= 32'd0;
      cache_valid_q <= 1'b0;
      cache_dvd_q   <= 32'd0;
      cache_dvs_q   <= 32'd0;
      cache_quo_q   <= 32'd0;
      cache_rem_q   <= 32'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      dvd_neg_q     <= dvd_neg_d;
      q_neg_q       <= q_neg_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      cache_valid_q <= cache_valid_d;
      cache_dvd_q   <= cache_dvd_d;
      cache_dvs_q   <= cache_dvs_d;
      cache_quo_q   <= cache_quo_d;
      cache_rem_q   <= cache_rem_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Purpose  : Self-checking bench for div_ctrl with a behavioural divider and
//            a per-cycle expectation schedule built from operation rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_div, ex_divu, ex_flush;
  logic [31:0] rs_val, rt_val;
  logic        dv_en;
  logic [31:0] dv_divident, dv_divisor;
  logic [31:0] dv_quotient, dv_remainder;
  logic        dv_done;
  logic        stall_req, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  div_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_div(ex_div), .ex_divu(ex_divu), .ex_flush(ex_flush),
    .rs_val(rs_val), .rt_val(rt_val),
    .dv_en(dv_en), .dv_divident(dv_divident), .dv_divisor(dv_divisor),
    .dv_quotient(dv_quotient), .dv_remainder(dv_remainder), .dv_done(dv_done),
    .stall_req(stall_req), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural unsigned divider: busy 17 cycles after start, then idle.
  int dcnt = 0;
  always @(posedge clk) begin
    if (!rst) begin
      dcnt <= 0;
    end else if (dv_en) begin
      dcnt         <= 17;
      dv_quotient  <= (dv_divisor != 0) ? dv_divident / dv_divisor : 32'd0;
      dv_remainder <= (dv_divisor != 0) ? dv_divident % dv_divisor : 32'd0;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign dv_done = (dcnt == 0);

  // Expectation schedule indexed by cycle.
  logic        e_en[N], e_st[N], e_we[N];
  logic [31:0] e_lo[N], e_hi[N];
  int          n_chk = 0, n_err = 0;
  logic        chk_on = 1'b0;

  // Result-cache model: magnitudes of the last launched operation.
  logic        m_valid = 1'b0;
  logic [31:0] m_ka = 32'd0, m_kb = 32'd0;
  int          exp_wc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < N) begin
      chk("dv_en",     {31'd0, dv_en},     {31'd0, e_en[cyc]});
      chk("stall_req", {31'd0, stall_req}, {31'd0, e_st[cyc]});
      chk("hi_we",     {31'd0, hi_we},     {31'd0, e_we[cyc]});
      chk("lo_we",     {31'd0, lo_we},     {31'd0, e_we[cyc]});
      if (e_we[cyc]) begin
        chk("lo_wdata", lo_wdata, e_lo[cyc]);
        chk("hi_wdata", hi_wdata, e_hi[cyc]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < N; i++) begin
      e_en[i] = 1'b0; e_st[i] = 1'b0; e_we[i] = 1'b0;
    end
  endtask

  // Present an operation in the current cycle and schedule its expectations.
  task automatic issue(input logic d, input logic du, input logic [31:0] a, input logic [31:0] b);
    int          r;
    longint      qa, ra, sa, sb;
    logic [31:0] lo, hi, ma, mb;
    r = cyc;
    ex_valid = 1'b1; ex_div = d; ex_divu = du; ex_flush = 1'b0;
    rs_val = a; rt_val = b;
    if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF;
    end else begin
      if (d) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
      end
      qa = sa / sb; ra = sa % sb;
      lo = qa[31:0]; hi = ra[31:0];
    end
    ma = (d && a[31]) ? 32'd0 - a : a;
    mb = (d && b[31]) ? 32'd0 - b : b;
    e_st[r] = 1'b1;
    if (b == 32'd0 || (m_valid && ma == m_ka && mb == m_kb)) begin
      exp_wc = r + 1;
    end else begin
      e_en[r + 1] = 1'b1;
      for (int c = r + 1; c <= r + 19; c++) e_st[c] = 1'b1;
      exp_wc = r + 20;
      m_valid = 1'b1; m_ka = ma; m_kb = mb;
    end
    e_we[exp_wc] = 1'b1; e_lo[exp_wc] = lo; e_hi[exp_wc] = hi;
  endtask

  // Hold the instruction through its DONE cycle, then retire it.
  task automatic finish_op();
    while (cyc < exp_wc) tick();
    tick();
    ex_valid = 1'b0; ex_div = 1'b0; ex_divu = 1'b0; ex_flush = 1'b0;
  endtask

  task automatic run(input logic d, input logic du, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lo_lit, input logic [31:0] hi_lit, input string name);
    issue(d, du, a, b);
    finish_op();
    chk({name, " lo"}, lo_wdata, lo_lit);
    chk({name, " hi"}, hi_wdata, hi_lit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int r0;

  initial begin
    for (int i = 0; i < N; i++) begin
      e_en[i] = 1'b0; e_st[i] = 1'b0; e_we[i] = 1'b0; e_lo[i] = 32'd0; e_hi[i] = 32'd0;
    end
    rst = 1'b0; ex_valid = 1'b0; ex_div = 1'b0; ex_divu = 1'b0; ex_flush = 1'b0;
    rs_val = 32'd0; rt_val = 32'd0;
    tick();
    chk_on = 1'b1;
    tick(); tick();
    chk("reset dv_divident", dv_divident, 32'd0);
    chk("reset dv_divisor",  dv_divisor,  32'd0);
    chk("reset hi_wdata",    hi_wdata,    32'd0);
    chk("reset lo_wdata",    lo_wdata,    32'd0);
    rst = 1'b1;
    tick();

    // Flushed request in IDLE must not start anything.
    ex_valid = 1'b1; ex_div = 1'b1; ex_flush = 1'b1; rs_val = 32'd10; rt_val = 32'd3;
    tick(); tick();
    ex_valid = 1'b0; ex_div = 1'b0; ex_flush = 1'b0;
    tick();

    run(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, "divu 100/7");
    tick();
    run(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div -7/2");
    run(1'b0, 1'b1, 32'd7, 32'd2, 32'd3, 32'd1, "divu 7/2 hit");
    run(1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "div by zero");
    run(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div overflow");
    run(1'b1, 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, "div 100/-7");
    run(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "div -100/7 hit");
    tick();

    // Flush in the fifth WAIT cycle; next op must wait for the drain.
    r0 = cyc;
    issue(1'b0, 1'b1, 32'd50, 32'd3);
    while (cyc < r0 + 6) tick();
    ex_flush = 1'b1;
    clear_from(r0 + 7);
    tick();
    ex_flush = 1'b0; rs_val = 32'd9; rt_val = 32'd4;
    while (cyc < r0 + 20) tick();
    run(1'b0, 1'b1, 32'd9, 32'd4, 32'd2, 32'd1, "divu 9/4 after drain");
    tick();

    // Cache hit whose DONE cycle is flushed: no write.
    r0 = cyc;
    issue(1'b0, 1'b1, 32'd9, 32'd4);
    clear_from(r0 + 1);
    tick();
    ex_flush = 1'b1;
    tick();
    ex_valid = 1'b0; ex_divu = 1'b0; ex_flush = 1'b0;
    tick();

    // Reset in the middle of WAIT.
    r0 = cyc;
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    while (cyc < r0 + 5) tick();
    rst = 1'b0;
    clear_from(r0 + 6);
    tick();
    rst = 1'b1; ex_valid = 1'b0; ex_divu = 1'b0;
    m_valid = 1'b0; m_ka = 32'd0; m_kb = 32'd0;
    chk("midwait dv_divident", dv_divident, 32'd0);
    chk("midwait dv_divisor",  dv_divisor,  32'd0);
    chk("midwait hi_wdata",    hi_wdata,    32'd0);
    chk("midwait lo_wdata",    lo_wdata,    32'd0);
    tick();
    run(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, "divu 100/7 after reset");
    tick(); tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
